lock_seq_ctrl: RTL and testbench

//  Sequencing controller for the 4-bit digital lock. Owns the stored password, attempt counter,

---
 rtl/lock_seq_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lock_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl: sequencing controller for the 4-bit digital lock.
// Holds the stored password, the wrong-entry counter, the lockout timer and the alarm,
// and drives the L/U/P/- seven-segment display.
//
// Ports:
//   clk    - system clock, all state updates on posedge
//   rst    - synchronous reset, active-high
//   in     - password / new-password switches (PW_W bits)
//   enter  - one-cycle strobe that submits `in`
//   skey   - set-key switch, selects program mode while unlocked
//   led    - {locked, unlocked}; 2'b00 during lockout
//   seven  - display segments {a..g}
//   cnt    - consecutive wrong-entry count
//   alarm  - high throughout lockout
//   busy   - high in lockout (enter ignored)
//
// Optional feature: define AUTO_RELOCK_EN to relock after RELOCK_CYC idle cycles in UNLOCKED.

module lock_seq_ctrl #(
    parameter int unsigned     PW_W        = 4,
    parameter logic [PW_W-1:0] DEFAULT_PW  = 'b0111,
    parameter int unsigned     MAX_TRIES   = 3,
    parameter int unsigned     LOCKOUT_CYC = 16,
    parameter int unsigned     RELOCK_CYC  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PW_W-1:0] in,
    input  logic            enter,
    input  logic            skey,
    output logic [1:0]      led,
    output logic [6:0]      seven,
    output logic [1:0]      cnt,
    output logic            alarm,
    output logic            busy
);

    localparam int unsigned TMR_W = (LOCKOUT_CYC > 2) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [1:0] MAX_CNT = 2'(MAX_TRIES);

    localparam logic [6:0] SEG_L    = 7'b0001110;
    localparam logic [6:0] SEG_U    = 7'b0111110;
    localparam logic [6:0] SEG_P    = 7'b1100111;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    typedef enum logic [1:0] {StLocked, StUnlocked, StProgram, StLockout} state_e;

    state_e          state_q, state_d;
    logic [PW_W-1:0] pw_q, pw_d;
    logic [PW_W-1:0] cand_q, cand_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]      led_q, led_d;
    logic [6:0]      seven_q, seven_d;
    logic            alarm_q, alarm_d;
    logic            busy_q, busy_d;
    logic [1:0]      cnt_inc;

`ifdef AUTO_RELOCK_EN
    localparam int unsigned IDLE_W = (RELOCK_CYC > 2) ? $clog2(RELOCK_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RELOCK_CYC - 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              relock;
    assign relock = (idle_q == IDLE_LAST);
`else
    logic unused_relock;
    assign unused_relock = ^RELOCK_CYC;
`endif

    // cnt_q < MAX_TRIES <= 3 whenever this is used, so it cannot wrap.
    assign cnt_inc = cnt_q + 2'd1;

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        unique case (state_q)
            StLocked: begin
                if (enter) begin
                    if (in == pw_q) begin
                        state_d = StUnlocked;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == MAX_CNT) begin
                            state_d = StLockout;
                            timer_d = TMR_LOAD;
                        end
                    end
                end
            end
            StUnlocked: begin
                if (enter) begin
                    if (skey) begin
                        cand_d  = in;
                        state_d = StProgram;
                    end else begin
                        state_d = StLocked;
                    end
                end
`ifdef AUTO_RELOCK_EN
                else if (relock) begin
                    state_d = StLocked;
                end
`endif
            end
            StProgram: begin
                // Dropping skey abandons programming even if enter arrives the same cycle.
                if (!skey) begin
                    state_d = StUnlocked;
                    cand_d  = '0;
                end else if (enter) begin
                    if (in == cand_q) begin
                        pw_d    = cand_q;
                        state_d = StLocked;
                    end else begin
                        state_d = StUnlocked;
                    end
                end
            end
            StLockout: begin
                if (timer_q == '0) begin
                    state_d = StLocked;
                    cnt_d   = 2'd0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = StLocked;
        endcase
    end

`ifdef AUTO_RELOCK_EN
    // Counts only consecutive idle cycles spent in UNLOCKED; zero on entry and on any enter.
    always_comb begin
        idle_d = '0;
        if (state_q == StUnlocked && state_d == StUnlocked && !enter) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end
`endif

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        led_d   = 2'b10;
        seven_d = SEG_L;
        alarm_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_d)
            StLocked: begin
                led_d   = 2'b10;
                seven_d = SEG_L;
            end
            StUnlocked: begin
                led_d   = 2'b01;
                seven_d = SEG_U;
            end
            StProgram: begin
                led_d   = 2'b01;
                seven_d = SEG_P;
            end
            StLockout: begin
                led_d   = 2'b00;
                seven_d = SEG_DASH;
                alarm_d = 1'b1;
                busy_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLocked;
            pw_q    <= DEFAULT_PW;
            cand_q  <= '0;
            cnt_q   <= 2'd0;
            timer_q <= '0;
            led_q   <= 2'b10;
            seven_q <= SEG_L;
            alarm_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef AUTO_RELOCK_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            led_q   <= led_d;
            seven_q <= seven_d;
            alarm_q <= alarm_d;
            busy_q  <= busy_d;
`ifdef AUTO_RELOCK_EN
            idle_q  <= idle_d;
`endif
        end
    end

    assign led   = led_q;
    assign seven = seven_q;
    assign cnt   = cnt_q;
    assign alarm = alarm_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Self-checking bench for lock_seq_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a cycle-stamped behavioural model of the lock.

module tb_lock_seq_ctrl;

    localparam int LOCKOUT_CYC = 16;
    localparam int RELOCK_CYC  = 32;
    localparam int MAX_TRIES   = 3;
`ifdef AUTO_RELOCK_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int M_LOCKED = 0, M_UNLOCKED = 1, M_PROGRAM = 2, M_LOCKOUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_s = 4'd0;
    logic       enter_s = 1'b0;
    logic       skey_s = 1'b0;
    logic [1:0] led;
    logic [6:0] seven;
    logic [1:0] cnt;
    logic       alarm;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Model: lock mode plus the cycle stamps at which timed modes were entered.
    int       cyc = 0;
    int       m_st = M_LOCKED;
    logic [3:0] m_pw = 4'b0111;
    logic [3:0] m_cand = 4'd0;
    int       m_cnt = 0;
    int       m_out_at = 0;
    int       m_unl_at = 0;

    lock_seq_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in_s),
        .enter(enter_s),
        .skey (skey_s),
        .led  (led),
        .seven(seven),
        .cnt  (cnt),
        .alarm(alarm),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st   = M_LOCKED;
        m_pw   = 4'b0111;
        m_cand = 4'd0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic [3:0] i, input logic e, input logic s);
        case (m_st)
            M_LOCKED: if (e) begin
                if (i == m_pw) begin
                    m_st = M_UNLOCKED; m_cnt = 0; m_unl_at = cyc;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == MAX_TRIES) begin
                        m_st = M_LOCKOUT; m_out_at = cyc;
                    end
                end
            end
            M_UNLOCKED: begin
                if (e) begin
                    if (s) begin m_cand = i; m_st = M_PROGRAM; end
                    else m_st = M_LOCKED;
                end else if (AUTO && (cyc - m_unl_at == RELOCK_CYC)) begin
                    m_st = M_LOCKED;
                end
            end
            M_PROGRAM: begin
                if (!s) begin
                    m_st = M_UNLOCKED; m_unl_at = cyc;
                end else if (e) begin
                    if (i == m_cand) begin m_pw = m_cand; m_st = M_LOCKED; end
                    else begin m_st = M_UNLOCKED; m_unl_at = cyc; end
                end
            end
            default: if (cyc - m_out_at == LOCKOUT_CYC) begin
                m_st = M_LOCKED; m_cnt = 0;
            end
        endcase
    endtask

    task automatic check();
        logic [1:0] e_led;
        logic [6:0] e_seven;
        logic       e_alarm;
        e_alarm = (m_st == M_LOCKOUT);
        case (m_st)
            M_LOCKED:   begin e_led = 2'b10; e_seven = 7'b0001110; end
            M_UNLOCKED: begin e_led = 2'b01; e_seven = 7'b0111110; end
            M_PROGRAM:  begin e_led = 2'b01; e_seven = 7'b1100111; end
            default:    begin e_led = 2'b00; e_seven = 7'b0000001; end
        endcase
        total++;
        assert (led === e_led) else begin
            bad++; $error("FAIL led cyc=%0d got=%b exp=%b", cyc, led, e_led);
        end
        total++;
        assert (seven === e_seven) else begin
            bad++; $error("FAIL seven cyc=%0d got=%b exp=%b", cyc, seven, e_seven);
        end
        total++;
        assert (cnt === 2'(m_cnt)) else begin
            bad++; $error("FAIL cnt cyc=%0d got=%0d exp=%0d", cyc, cnt, m_cnt);
        end
        total++;
        assert (alarm === e_alarm) else begin
            bad++; $error("FAIL alarm cyc=%0d got=%b exp=%b", cyc, alarm, e_alarm);
        end
        total++;
        assert (busy === e_alarm) else begin
            bad++; $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_alarm);
        end
    endtask

    task automatic step(input logic [3:0] i, input logic e, input logic s);
        in_s = i; enter_s = e; skey_s = s;
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else model_step(i, e, s);
        #1;
        check();
        enter_s = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(4'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input logic s);
        for (int k = 0; k < n; k++) step(4'd0, 1'b0, s);
    endtask

    initial begin
        // 1: reset state, correct password unlocks next cycle
        do_reset();
        step(4'b0111, 1'b1, 1'b0);
        idle(2, 1'b0);

        // 2: three wrong entries -> lockout; enters ignored; exact 16-cycle dwell
        do_reset();
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0111, 1'b1, 1'b0);
        idle(13, 1'b0);
        step(4'b0111, 1'b1, 1'b0);   // coincides with expiry, must be ignored
        idle(2, 1'b0);

        // 3: program 1010, old password then rejected, new one accepted
        step(4'b0111, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 1'b1);
        step(4'b1010, 1'b1, 1'b1);
        step(4'b0111, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 1'b0);

        // 4: mismatched confirm and skey-drop both leave pw unchanged
        do_reset();
        step(4'b0111, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 1'b1);
        step(4'b1100, 1'b1, 1'b1);
        step(4'b1010, 1'b1, 1'b1);
        step(4'b1010, 1'b1, 1'b0);   // skey low wins over enter
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 1'b0);
        step(4'b0111, 1'b1, 1'b0);

        // 5: two wrong then correct clears cnt; one more wrong gives cnt=1
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0111, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0011, 1'b1, 1'b0);

        // 6: reset mid-lockout and mid-program
        do_reset();
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        idle(5, 1'b0);
        do_reset();
        step(4'b0111, 1'b1, 1'b0);
        step(4'b1001, 1'b1, 1'b1);
        do_reset();
        step(4'b1001, 1'b1, 1'b0);
        step(4'b0111, 1'b1, 1'b0);

        // Idle in UNLOCKED: holds without auto-relock, relocks after 32 cycles with it
        idle(40, 1'b0);

        // Random phase
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] r_in;
            logic       r_en;
            logic       r_sk;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 3))
                    0: r_in = m_pw;
                    1: r_in = m_cand;
                    default: r_in = 4'($urandom);
                endcase
                r_en = ($urandom_range(0, 2) == 0);
                r_sk = ($urandom_range(0, 3) != 0);
                step(r_in, r_en, r_sk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
